// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the four-phase request/acknowledge CDC handshake.
// Holds the handshake state encoding and the legal synchronizer depth range.
// Both the transmit side and the future receive side import this package.
package cdc_hs_pkg;

  // Legal number of flop stages in a handshake synchronizer
  localparam int unsigned NrLevelsMin = 2;
  localparam int unsigned NrLevelsMax = 4;

  // Source-side handshake phases
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for single-bit (or Gray-safe) control signals that
// arrive from another clock domain.
// Ports:
//   clk  in   destination clock
//   rst  in   synchronous active-high reset, clears every stage
//   d    in   Width  asynchronous input
//   q    out  Width  synchronized output (last stage)
module sync_ff_chain
  import cdc_hs_pkg::*;
#(
  parameter int unsigned Width    = 1,
  parameter int unsigned NrLevels = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  if (NrLevels < NrLevelsMin || NrLevels > NrLevelsMax) begin : g_bad_levels
    $error("sync_ff_chain: NrLevels must be within 2..4");
  end

  // stages[0] is the metastability-catching flop, stages[NrLevels-1] is safe to use
  logic [NrLevels-1:0][Width-1:0] stages;

  // Shift the input through the chain
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[NrLevels-2:0], d};
    end
  end

  assign q = stages[NrLevels-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side half of a four-phase req/ack clock-domain crossing. Accepts one
// word from a valid/ready producer, holds it on data_o while req_o is high,
// drops req_o once the synchronized ack is seen, then waits for ack to clear.
// Ports:
//   i_clk    in   source-domain clock
//   i_rst    in   synchronous active-high reset
//   data_i   in   DataW  word to send, captured on accept
//   valid_i  in   producer has a word
//   ready_o  out  combinational: IDLE and synchronized ack low
//   req_o    out  registered request to the destination domain
//   data_o   out  DataW  registered hold value, stable while req_o is high
//   ack_i    in   asynchronous acknowledge from the destination domain
//   busy_o   out  registered, high during REQ and RELEASE
//   done_o   out  registered one-cycle pulse when a handshake completes
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DataW    = 32,
  parameter int unsigned NrLevels = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DataW-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             req_o,
  output logic [DataW-1:0] data_o,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             done_o
);

  if (NrLevels < NrLevelsMin || NrLevels > NrLevelsMax) begin : g_bad_levels
    $error("cdc_handshake_tx: NrLevels must be within 2..4");
  end

  hs_state_e        state_q, state_d;
  logic             req_d;
  logic [DataW-1:0] data_d;
  logic             busy_d;
  logic             done_d;
  logic             ack_s;

  // Ack synchronizer; only ack_s is used past this point
  sync_ff_chain #(
    .Width    (1),
    .NrLevels (NrLevels)
  ) u_ack_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (ack_i),
    .q   (ack_s)
  );

  // A stale ack left over from a reset-truncated handshake blocks new requests
  assign ready_o = (state_q == IDLE) && !ack_s;

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      req_o   <= 1'b0;
      data_o  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_o   <= req_d;
      data_o  <= data_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    req_d   = req_o;
    data_d  = data_o;
    busy_d  = busy_o;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          data_d  = data_i;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Testbench for cdc_handshake_tx: two instances (NrLevels 2 and 3) driven by a
// randomized producer and a random-latency destination responder. Expected
// timing comes from the handshake rules: req falls NrLevels edges after the
// edge that first sees ack high, done pulses NrLevels edges after ack falls.
module tb_cdc_handshake_tx;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic [31:0] din   [2];
  logic        valid [2];
  logic        ready [2];
  logic        req   [2];
  logic [31:0] dout  [2];
  logic        ack   [2];
  logic        busy  [2];
  logic        done  [2];

  int n_chk  = 0;
  int n_pass = 0;
  int cur    = 0;
  int done_cnt [2];
  logic [31:0] sent_q [$];
  logic [31:0] rx_q   [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cdc_handshake_tx #(
      .DataW    (32),
      .NrLevels (g + 2)
    ) u_dut (
      .i_clk   (clk),
      .i_rst   (rst[g]),
      .data_i  (din[g]),
      .valid_i (valid[g]),
      .ready_o (ready[g]),
      .req_o   (req[g]),
      .data_o  (dout[g]),
      .ack_i   (ack[g]),
      .busy_o  (busy[g]),
      .done_o  (done[g])
    );
  end

  function automatic int lv(input int k);
    return k + 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s (NrLevels=%0d) t=%0t: got %0h expected %0h", tag, cur + 2, $time, got, exp);
    else
      n_pass++;
  endtask

  // One clock: inputs change after the falling edge, outputs sampled there too
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      if (done[k]) done_cnt[k]++;
  endtask

  // Full handshake of one word with responder latencies lr (to ack rise) and lf (ack hold)
  task automatic send_word(input int k, input logic [31:0] w, input int lr, input int lf);
    int waited;
    int l;
    l = lv(k);
    waited = 0;
    valid[k] = 1'b1;
    din[k]   = w;
    while (!ready[k] && waited < 64) begin
      step();
      waited++;
    end
    check("ready_before_accept", 32'(ready[k]), 32'd1);
    if (!ready[k]) begin
      valid[k] = 1'b0;
      return;
    end
    check("req_low_before_accept", 32'(req[k]), 32'd0);
    step();
    sent_q.push_back(w);
    check("req_rise", 32'(req[k]), 32'd1);
    check("data_on_accept", dout[k], w);
    check("busy_set", 32'(busy[k]), 32'd1);
    check("done_cleared", 32'(done[k]), 32'd0);
    // REQ: producer scribbles on data/valid, which must be ignored
    for (int i = 0; i < lr; i++) begin
      valid[k] = 1'($urandom);
      din[k]   = $urandom;
      step();
      check("req_hold", 32'(req[k]), 32'd1);
      check("data_hold_req", dout[k], w);
      check("ready_low_req", 32'(ready[k]), 32'd0);
    end
    ack[k] = 1'b1;
    rx_q.push_back(dout[k]);
    for (int n = 1; n <= l + 1; n++) begin
      valid[k] = 1'($urandom);
      din[k]   = $urandom;
      step();
      check("req_fall_timing", 32'(req[k]), 32'(n <= l));
      check("data_hold_ack", dout[k], w);
      check("ready_low_ack", 32'(ready[k]), 32'd0);
      check("busy_ack", 32'(busy[k]), 32'd1);
    end
    for (int i = 0; i < lf; i++) begin
      valid[k] = 1'($urandom);
      din[k]   = $urandom;
      step();
      check("req_low_release", 32'(req[k]), 32'd0);
      check("no_early_done", 32'(done[k]), 32'd0);
      check("data_hold_release", dout[k], w);
    end
    valid[k] = 1'b0;
    ack[k]   = 1'b0;
    for (int n = 1; n <= l + 1; n++) begin
      step();
      check("done_timing", 32'(done[k]), 32'(n == l + 1));
      check("ready_return", 32'(ready[k]), 32'(n == l + 1));
      check("busy_clear", 32'(busy[k]), 32'(n <= l));
      check("data_hold_done", dout[k], w);
    end
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_req", 32'(req[k]), 32'd0);
    check("rst_data", dout[k], 32'd0);
    check("rst_busy", 32'(busy[k]), 32'd0);
    check("rst_done", 32'(done[k]), 32'd0);
  endtask

  initial begin
    int d0;
    int l;
    logic [31:0] base;
    logic [31:0] exp_w;
    logic [31:0] got_w;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; din[k] = '0; valid[k] = 1'b0; ack[k] = 1'b0; done_cnt[k] = 0;
    end
    repeat (3) step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cur = k;
      check_reset_outputs(k);
      check("rst_ready", 32'(ready[k]), 32'd1);
    end

    for (int k = 0; k < 2; k++) begin
      cur = k;
      l = lv(k);

      // Single word with a fixed 3-cycle responder
      sent_q.delete(); rx_q.delete();
      d0 = done_cnt[k];
      send_word(k, 32'hDEADBEEF, 3, 3);
      step();
      check("single_done_count", 32'(done_cnt[k] - d0), 32'd1);
      check("single_rx", (rx_q.size() > 0) ? rx_q[0] : 32'hX, 32'hDEADBEEF);
      check("single_done_pulse", 32'(done[k]), 32'd0);
      check("single_ready", 32'(ready[k]), 32'd1);

      // 100 back-to-back incrementing words, random responder latency
      sent_q.delete(); rx_q.delete();
      d0 = done_cnt[k];
      base = $urandom;
      for (int i = 0; i < 100; i++)
        send_word(k, base + 32'(i), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      check("b2b_done_count", 32'(done_cnt[k] - d0), 32'd100);
      check("b2b_rx_count", 32'(rx_q.size()), 32'd100);
      for (int i = 0; i < 100; i++) begin
        exp_w = base + 32'(i);
        got_w = (i < rx_q.size()) ? rx_q[i] : 32'hX;
        check("b2b_rx_order", got_w, exp_w);
      end

      // Reset while in REQ with ack held high by the destination
      valid[k] = 1'b1;
      din[k]   = 32'hA5A5_0000 + 32'(k);
      check("rr_ready", 32'(ready[k]), 32'd1);
      step();
      valid[k] = 1'b0;
      check("rr_req", 32'(req[k]), 32'd1);
      ack[k] = 1'b1;
      step();
      check("rr_still_req", 32'(req[k]), 32'd1);
      rst[k] = 1'b1;
      step();
      rst[k] = 1'b0;
      check_reset_outputs(k);
      for (int i = 1; i <= 10; i++) begin
        step();
        if (i >= l) check("rr_stale_ack_blocks", 32'(ready[k]), 32'd0);
        check("rr_no_req", 32'(req[k]), 32'd0);
      end
      ack[k] = 1'b0;
      for (int n = 1; n <= l + 1; n++) begin
        step();
        check("rr_ready_after_ack_fall", 32'(ready[k]), 32'(n >= l));
        check("rr_no_done", 32'(done[k]), 32'd0);
      end

      // Destination never acknowledges: stuck in REQ, no timeout
      valid[k] = 1'b1;
      din[k]   = 32'h1234_5678;
      step();
      valid[k] = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        check("stuck_req", 32'(req[k]), 32'd1);
        check("stuck_busy", 32'(busy[k]), 32'd1);
        check("stuck_no_done", 32'(done[k]), 32'd0);
        check("stuck_data", dout[k], 32'h1234_5678);
      end
      rst[k] = 1'b1;
      step();
      rst[k] = 1'b0;
      check_reset_outputs(k);
      check("stuck_rst_ready", 32'(ready[k]), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
